wb_stage: RTL and testbench

Write-back pipeline stage of the core. It accepts one instruction per handshake from the memory stage. It waits for load data from the data RAM when required, then selects and sign/zero-extends the write-back value. It drives the register file write port (`we`, `wa`, `wd`) together with the `valid_wb` / `ready_go_wb` qualifiers that the register file ANDs into its write enable and its read-forwarding path.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
// Takes one instruction per handshake from the memory stage, waits for load
// data when the instruction is a load, extends it, and drives the register
// file write port plus the valid/ready-go qualifiers.
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retire counter.
module wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem,
  output logic                  allow_in_wb,
  input  logic                  mem_we,
  input  logic [RD_WIDTH-1:0]   mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_WIDTH-1:0] mem_alu_res,
  input  logic [DATA_WIDTH-1:0] mem_pc,
  input  logic [2:0]            mem_funct3,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_rvalid,
  input  logic                  allow_in_regfile,
  output logic                  we,
  output logic [RD_WIDTH-1:0]   wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  valid_wb,
  output logic                  ready_go_wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam logic [1:0]  SEL_LOAD = 2'b01;
  localparam logic [1:0]  SEL_PC4  = 2'b10;

  logic                  we_q;
  logic [RD_WIDTH-1:0]   rd_q;
  logic [1:0]            wb_sel_q;
  logic [DATA_WIDTH-1:0] alu_res_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [2:0]            funct3_q;
  logic                  load_got;
  logic [WORD_W-1:0]     load_buf;

  logic                  int_ready;
  logic                  accept;
  logic                  capture;
  logic [WORD_W-1:0]     load_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [WORD_W-1:0]     load_ext;

  // Handshake: completion, acceptance and early load capture
  always_comb begin
    int_ready   = 1'b0;
    ready_go_wb = 1'b0;
    allow_in_wb = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    int_ready   = (wb_sel_q != SEL_LOAD) | load_got | dmem_rvalid;
    ready_go_wb = valid_wb & int_ready & allow_in_regfile;
    allow_in_wb = ~valid_wb | ready_go_wb;
    accept      = valid_mem & allow_in_wb;
    // A response arriving in the completing cycle is consumed via the bypass
    capture     = valid_wb & (wb_sel_q == SEL_LOAD) & ~load_got & dmem_rvalid
                  & ~ready_go_wb;
  end

  // Stage registers: accept latches a new instruction, drain empties, capture buffers load data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_wb  <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= '0;
      alu_res_q <= '0;
      pc_q      <= '0;
      funct3_q  <= '0;
      load_got  <= 1'b0;
      load_buf  <= '0;
    end else if (accept) begin
      valid_wb  <= 1'b1;
      we_q      <= mem_we;
      rd_q      <= mem_rd;
      wb_sel_q  <= mem_wb_sel;
      alu_res_q <= mem_alu_res;
      pc_q      <= mem_pc;
      funct3_q  <= mem_funct3;
      load_got  <= 1'b0;
    end else if (ready_go_wb) begin
      valid_wb  <= 1'b0;
    end else if (capture) begin
      load_got  <= 1'b1;
      load_buf  <= dmem_rdata;
    end
  end

  // Load data selection and byte/half extension
  always_comb begin
    load_word = '0;
    ld_byte   = '0;
    ld_half   = '0;
    load_ext  = '0;
    load_word = load_got ? load_buf : dmem_rdata;
    case (alu_res_q[1:0])
      2'b00:   ld_byte = load_word[7:0];
      2'b01:   ld_byte = load_word[15:8];
      2'b10:   ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = alu_res_q[1] ? load_word[31:16] : load_word[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b101:  load_ext = {16'b0, ld_half};
      default: load_ext = load_word;
    endcase
  end

  // Register file write port
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    we = valid_wb & we_q;
    wa = rd_q;
    case (wb_sel_q)
      SEL_LOAD: wd = DATA_WIDTH'(load_ext);
      SEL_PC4:  wd = pc_q + DATA_WIDTH'(4);
      default:  wd = alu_res_q;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  // Count completed instructions, wrapping at 2^64
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (ready_go_wb) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cycle table, a reset-during-load sequence and
// randomized traffic checked against a transaction-level model.
module tb_wb_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_mem;
  logic          allow_in_wb;
  logic          mem_we;
  logic [RW-1:0] mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [DW-1:0] mem_alu_res;
  logic [DW-1:0] mem_pc;
  logic [2:0]    mem_funct3;
  logic [31:0]   dmem_rdata;
  logic          dmem_rvalid;
  logic          allow_in_regfile;
  logic          we;
  logic [RW-1:0] wa;
  logic [DW-1:0] wd;
  logic          valid_wb;
  logic          ready_go_wb;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]   retire_cnt;
`endif

  always #5 clk = ~clk;

  wb_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem), .allow_in_wb(allow_in_wb),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
    .mem_alu_res(mem_alu_res), .mem_pc(mem_pc), .mem_funct3(mem_funct3),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .allow_in_regfile(allow_in_regfile), .we(we), .wa(wa), .wd(wd),
    .valid_wb(valid_wb), .ready_go_wb(ready_go_wb)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit        we;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [31:0] alu;
    bit [31:0] pc;
    bit [2:0]  f3;
  } instr_t;

  instr_t          held[$];     // instruction occupying the stage (0 or 1)
  bit              have_data;
  bit [31:0]       got_data;
  longint unsigned retired = 0;

  function automatic bit [31:0] extend(input bit [31:0] word, input bit [2:0] f3,
                                       input bit [31:0] addr);
    bit [31:0] b;
    bit [31:0] h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic bit m_ready();
    if (held.size() == 0 || !allow_in_regfile) return 1'b0;
    return (held[0].sel != 2'b01) || have_data || dmem_rvalid;
  endfunction

  function automatic bit [31:0] m_wd();
    if (held[0].sel == 2'b10) return held[0].pc + 32'd4;
    if (held[0].sel == 2'b01) return extend(have_data ? got_data : dmem_rdata, held[0].f3, held[0].alu);
    return held[0].alu;
  endfunction

  // Advance the model across the coming clock edge using the current inputs
  task automatic model_edge();
    bit     rdy;
    bit     acc;
    instr_t n;
    if (!rst_n) begin
      held.delete();
      have_data = 1'b0;
      retired   = 0;
      return;
    end
    rdy = m_ready();
    acc = valid_mem && (held.size() == 0 || rdy);
    if (rdy) begin
      retired++;
      void'(held.pop_front());
    end else if (held.size() != 0 && held[0].sel == 2'b01 && !have_data && dmem_rvalid) begin
      have_data = 1'b1;
      got_data  = dmem_rdata;
    end
    if (acc) begin
      n.we = mem_we; n.rd = mem_rd; n.sel = mem_wb_sel;
      n.alu = mem_alu_res; n.pc = mem_pc; n.f3 = mem_funct3;
      held.push_back(n);
      have_data = 1'b0;
    end
  endtask

  task automatic model_check();
    bit rdy;
    rdy = m_ready();
    chk("m_allow_in_wb", 64'(allow_in_wb), 64'(held.size() == 0 || rdy));
    chk("m_ready_go_wb", 64'(ready_go_wb), 64'(rdy));
    chk("m_valid_wb",    64'(valid_wb),    64'(held.size() != 0));
    chk("m_we",          64'(we),          64'(held.size() != 0 && held[0].we));
    if (held.size() != 0) begin
      chk("m_wa", 64'(wa), 64'(held[0].rd));
      chk("m_wd", 64'(wd), 64'(m_wd()));
    end
`ifdef WB_RETIRE_CNT_EN
    chk("m_retire_cnt", retire_cnt, 64'(retired));
`endif
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit        rst_n, vm, mwe;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [31:0] alu, pc;
    bit [2:0]  f3;
    bit [31:0] rdata;
    bit        rv, arf;
    bit        chk, chkwd;
    bit        e_allow, e_rg, e_valid, e_we;
    bit [4:0]  e_wa;
    bit [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, vm, mwe, input bit [4:0] rd, input bit [1:0] sel,
                     input bit [31:0] alu, pc, input bit [2:0] f3, input bit [31:0] rdata,
                     input bit rv, arf, c, cwd, ea, erg, ev, ewe,
                     input bit [4:0] ewa, input bit [31:0] ewd);
    vec_t v;
    v.rst_n = r; v.vm = vm; v.mwe = mwe; v.rd = rd; v.sel = sel; v.alu = alu; v.pc = pc;
    v.f3 = f3; v.rdata = rdata; v.rv = rv; v.arf = arf; v.chk = c; v.chkwd = cwd;
    v.e_allow = ea; v.e_rg = erg; v.e_valid = ev; v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; valid_mem = v.vm; mem_we = v.mwe; mem_rd = v.rd; mem_wb_sel = v.sel;
    mem_alu_res = v.alu; mem_pc = v.pc; mem_funct3 = v.f3; dmem_rdata = v.rdata;
    dmem_rvalid = v.rv; allow_in_regfile = v.arf;
  endtask

  task automatic check_vec(input vec_t v);
    if (!v.chk) return;
    chk("allow_in_wb", 64'(allow_in_wb), 64'(v.e_allow));
    chk("ready_go_wb", 64'(ready_go_wb), 64'(v.e_rg));
    chk("valid_wb",    64'(valid_wb),    64'(v.e_valid));
    chk("we",          64'(we),          64'(v.e_we));
    if (v.chkwd) begin
      chk("wa", 64'(wa), 64'(v.e_wa));
      chk("wd", 64'(wd), 64'(v.e_wd));
    end
  endtask

  vec_t idle;

  initial begin
    idle = '{rst_n: 1'b1, arf: 1'b1, default: '0};
    drive(idle);
    rst_n = 1'b0;

    //   rst vm we rd sel alu           pc            f3 rdata          rv arf chk cwd  al rg v  we wa wd
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  0, 0,   0, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   1, 0, 0, 0, 0, 32'h0);
    // ALU op, rd=5
    add(1, 1, 1, 5, 0, 32'h1234,     32'h100,      0, 32'h0,         0, 1,  1, 1,   1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   1, 1, 1, 1, 5, 32'h1234);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 0,   1, 0, 0, 0, 0, 32'h0);
    // LB at offset 3, data three cycles after accept
    add(1, 1, 1, 7, 1, 32'h1003,     32'h104,      0, 32'h0,         0, 1,  1, 0,   1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   0, 0, 1, 1, 7, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   0, 0, 1, 1, 7, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h80FF0000,  1, 1,  1, 1,   1, 1, 1, 1, 7, 32'hFFFFFF80);
    // LHU at offset 2, data arrives while the register file stalls
    add(1, 1, 1, 9, 1, 32'h2002,     32'h108,      5, 32'h0,         0, 1,  1, 0,   1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'hBEEF0000,  1, 0,  1, 1,   0, 0, 1, 1, 9, 32'h0000BEEF);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h12345678,  0, 0,  1, 1,   0, 0, 1, 1, 9, 32'h0000BEEF);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'hDEAD0000,  1, 0,  1, 1,   0, 0, 1, 1, 9, 32'h0000BEEF);
    // release, with a JAL at pc=0xFFFFFFFC accepted back-to-back, then an ALU (sel 11)
    add(1, 1, 1, 1, 2, 32'h55,       32'hFFFFFFFC, 0, 32'h0,         0, 1,  1, 1,   1, 1, 1, 1, 9, 32'h0000BEEF);
    add(1, 1, 1, 3, 3, 32'hCAFE,     32'h10,       0, 32'h0,         0, 1,  1, 1,   1, 1, 1, 1, 1, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   1, 1, 1, 1, 3, 32'hCAFE);
    // LH with addr[0] set, then LBU, then a non-writing ALU op, all back-to-back
    add(1, 1, 1, 4, 1, 32'h3003,     32'h20,       1, 32'h0,         0, 1,  1, 0,   1, 0, 0, 0, 0, 32'h0);
    add(1, 1, 1, 6, 1, 32'h1,        32'h24,       4, 32'h80017FFF,  1, 1,  1, 1,   1, 1, 1, 1, 4, 32'hFFFF8001);
    add(1, 1, 0, 2, 0, 32'h77,       32'h28,       0, 32'h0000F200,  1, 1,  1, 1,   1, 1, 1, 1, 6, 32'h000000F2);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 1,   1, 1, 1, 0, 2, 32'h77);
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,         0, 1,  1, 0,   1, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_vec(tbl[i]);
      model_edge();
    end

    // Reset while a load is waiting; the late response must be dropped
    @(negedge clk);
    drive(idle);
    valid_mem = 1'b1; mem_we = 1'b1; mem_rd = 5'd8; mem_wb_sel = 2'b01;
    mem_alu_res = 32'h40; mem_funct3 = 3'd2;
    #1;
    chk("rst_seq_accept_allow", 64'(allow_in_wb), 64'd1);
    model_edge();
    @(negedge clk);
    drive(idle);
    rst_n = 1'b0;
    #1;
    chk("rst_seq_waiting_valid", 64'(valid_wb), 64'd1);
    chk("rst_seq_waiting_rg",    64'(ready_go_wb), 64'd0);
    model_edge();
    @(negedge clk);
    drive(idle);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("rst_seq_valid", 64'(valid_wb),    64'd0);
    chk("rst_seq_allow", 64'(allow_in_wb), 64'd1);
    chk("rst_seq_rg",    64'(ready_go_wb), 64'd0);
    chk("rst_seq_we",    64'(we),          64'd0);
    chk("rst_seq_wa",    64'(wa),          64'd0);
    chk("rst_seq_wd",    64'(wd),          64'd0);
    model_edge();
    @(negedge clk);
    drive(idle);
    #1;
    chk("rst_seq_after_valid", 64'(valid_wb), 64'd0);
    chk("rst_seq_after_we",    64'(we),       64'd0);
    model_edge();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n            = ($urandom_range(0, 99) != 0);
      valid_mem        = ($urandom_range(0, 3) != 0);
      mem_we           = $urandom_range(0, 1) != 0;
      mem_rd           = 5'($urandom);
      mem_wb_sel       = 2'($urandom);
      mem_alu_res      = $urandom;
      mem_pc           = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      mem_funct3       = 3'($urandom);
      dmem_rdata       = $urandom;
      dmem_rvalid      = ($urandom_range(0, 2) == 0);
      allow_in_regfile = ($urandom_range(0, 3) != 0);
      #1;
      model_check();
      model_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
